// File: rtl/execute_pkg.sv
// Shared encodings for the execute stage: ALU ops, branch funct3, M-ops,
// forwarding selects and the multiply/divide FSM state.
package execute_pkg;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLT   = 4'd5;
    localparam logic [3:0] ALU_SLTU  = 4'd6;
    localparam logic [3:0] ALU_SLL   = 4'd7;
    localparam logic [3:0] ALU_SRL   = 4'd8;
    localparam logic [3:0] ALU_SRA   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    localparam logic [1:0] FWD_RD = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } md_state_t;

endpackage

// File: rtl/execute_stage_md_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage; master = pipeline, slave = stage.
// Handshake: the stage accepts the EX instruction on any edge where StallE is low;
// while StallE is high the pipeline must hold every *E input stable.
interface execute_stage_md_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    import execute_pkg::*;

    logic              ValidE, FlushE;
    logic              RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcE, MdEnE;
    logic [1:0]        ResultSrcE;
    logic [3:0]        ALUControlE;
    logic [2:0]        BranchOpE, MdOpE;
    logic [XLEN-1:0]   RD1E, RD2E, PCE, ImmExtE, PCPlus4E, ResultW;
    logic [REG_AW-1:0] RdE;
    logic [1:0]        ForwardAE, ForwardBE;

    logic              PCSrcE;
    logic [XLEN-1:0]   PCTargetE;
    logic              StallE;
    logic              RegWriteM, MemWriteM;
    logic [1:0]        ResultSrcM;
    logic [XLEN-1:0]   ALUResultM, WriteDataM, PCPlus4M;
    logic [REG_AW-1:0] RdM;
    md_state_t         MdStateE;

    modport master (
        output ValidE, FlushE, RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcE, MdEnE,
               ResultSrcE, ALUControlE, BranchOpE, MdOpE, RD1E, RD2E, PCE, ImmExtE,
               PCPlus4E, ResultW, RdE, ForwardAE, ForwardBE,
        input  PCSrcE, PCTargetE, StallE, RegWriteM, MemWriteM, ResultSrcM, ALUResultM,
               WriteDataM, PCPlus4M, RdM, MdStateE
    );

    modport slave (
        input  ValidE, FlushE, RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcE, MdEnE,
               ResultSrcE, ALUControlE, BranchOpE, MdOpE, RD1E, RD2E, PCE, ImmExtE,
               PCPlus4E, ResultW, RdE, ForwardAE, ForwardBE,
        output PCSrcE, PCTargetE, StallE, RegWriteM, MemWriteM, ResultSrcM, ALUResultM,
               WriteDataM, PCPlus4M, RdM, MdStateE
    );

endinterface

// File: rtl/md_unit_iter.sv
// Iterative RV32M unit: one shift-add or restoring shift-subtract step per cycle
// on operand magnitudes, with sign and divide-by-zero fixup in DONE.
module md_unit_iter
    import execute_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output md_state_t       state_o
);
    localparam int CW = $clog2(XLEN);

    md_state_t         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic [2:0]        op_q, op_d;
    logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d, bzero_q, bzero_d;

    logic              a_signed, b_signed, sa, sb, ge;
    logic [XLEN-1:0]   mag_a, mag_b, shl, diff, quo, rem;
    logic [XLEN:0]     add_sum;
    logic [2*XLEN-1:0] prod, prod_fix;

    always_comb begin
        a_signed = (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
        b_signed = (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
        sa       = a_signed & a[XLEN-1];
        sb       = b_signed & b[XLEN-1];
        mag_a    = sa ? -a : a;
        mag_b    = sb ? -b : b;

        // hi_q < b_q holds throughout a divide, so the shifted partial remainder fits XLEN+1 bits.
        add_sum  = {1'b0, hi_q} + {1'b0, b_q};
        shl      = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
        ge       = {hi_q, lo_q[XLEN-1]} >= {1'b0, b_q};
        diff     = shl - b_q;

        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        b_d     = b_q;
        op_d    = op_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        bzero_d = bzero_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_BUSY;
                    cnt_d   = '0;
                    hi_d    = '0;
                    lo_d    = mag_a;
                    b_d     = mag_b;
                    op_d    = op;
                    neg_a_d = sa;
                    neg_b_d = sb;
                    bzero_d = (b == '0);
                end
            end
            S_BUSY: begin
                if (op_q[2]) begin
                    hi_d = ge ? diff : shl;
                    lo_d = {lo_q[XLEN-2:0], ge};
                end else if (lo_q[0]) begin
                    {hi_d, lo_d} = {add_sum, lo_q[XLEN-1:1]};
                end else begin
                    {hi_d, lo_d} = {1'b0, hi_q, lo_q[XLEN-1:1]};
                end
                if (cnt_q == CW'(XLEN - 1)) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d = S_IDLE;
        end
    end

    // Signed overflow needs no special case: |min|/1 negated wraps back to min, remainder 0.
    always_comb begin
        prod     = {hi_q, lo_q};
        prod_fix = (neg_a_q ^ neg_b_q) ? -prod : prod;
        quo      = bzero_q ? '1 : ((neg_a_q ^ neg_b_q) ? -lo_q : lo_q);
        rem      = neg_a_q ? -hi_q : hi_q;
        case (op_q)
            MD_MUL:                       result = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: result = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              result = quo;
            default:                      result = rem;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            op_q    <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            bzero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            b_q     <= b_d;
            op_q    <= op_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            bzero_q <= bzero_d;
        end
    end

    assign busy    = (state_q == S_BUSY);
    assign done    = (state_q == S_DONE);
    assign state_o = state_q;

endmodule

// File: rtl/execute_stage_md.sv
// Execute stage: forwarding, ALU, branch/jump resolution, iterative RV32M unit
// and the EX/MEM pipeline register.
module execute_stage_md
    import execute_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input logic               clk,
    input logic               rst,
    execute_stage_md_if.slave ex
);
    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0]   src_a, fwd_b, src_b, alu_result, md_result;
    logic [SHW-1:0]    shamt;
    logic              br_cond, md_busy, md_done, stall, bubble;
    md_state_t         md_state;

    logic              regwrite_m_q, regwrite_m_d, memwrite_m_q, memwrite_m_d;
    logic [1:0]        resultsrc_m_q, resultsrc_m_d;
    logic [XLEN-1:0]   aluresult_m_q, aluresult_m_d, writedata_m_q, writedata_m_d;
    logic [XLEN-1:0]   pcplus4_m_q, pcplus4_m_d;
    logic [REG_AW-1:0] rd_m_q, rd_m_d;

    function automatic logic [XLEN-1:0] fwd_sel(input logic [XLEN-1:0] rd,
                                                input logic [1:0]      sel,
                                                input logic [XLEN-1:0] res_w,
                                                input logic [XLEN-1:0] alu_m);
        logic [XLEN-1:0] v;
        case (sel)
            FWD_W:   v = res_w;
            FWD_M:   v = alu_m;
            default: v = rd;
        endcase
        return v;
    endfunction

    always_comb begin
        src_a = fwd_sel(ex.RD1E, ex.ForwardAE, ex.ResultW, aluresult_m_q);
        fwd_b = fwd_sel(ex.RD2E, ex.ForwardBE, ex.ResultW, aluresult_m_q);
        src_b = ex.ALUSrcE ? ex.ImmExtE : fwd_b;
        shamt = src_b[SHW-1:0];

        case (ex.ALUControlE)
            ALU_ADD:   alu_result = src_a + src_b;
            ALU_SUB:   alu_result = src_a - src_b;
            ALU_AND:   alu_result = src_a & src_b;
            ALU_OR:    alu_result = src_a | src_b;
            ALU_XOR:   alu_result = src_a ^ src_b;
            ALU_SLT:   alu_result = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            ALU_SLTU:  alu_result = {{(XLEN-1){1'b0}}, src_a < src_b};
            ALU_SLL:   alu_result = src_a << shamt;
            ALU_SRL:   alu_result = src_a >> shamt;
            ALU_SRA:   alu_result = $signed(src_a) >>> shamt;
            ALU_PASSB: alu_result = src_b;
            default:   alu_result = '0;
        endcase

        case (ex.BranchOpE)
            BR_EQ:   br_cond = (src_a == fwd_b);
            BR_NE:   br_cond = (src_a != fwd_b);
            BR_LT:   br_cond = $signed(src_a) < $signed(fwd_b);
            BR_GE:   br_cond = $signed(src_a) >= $signed(fwd_b);
            BR_LTU:  br_cond = src_a < fwd_b;
            BR_GEU:  br_cond = src_a >= fwd_b;
            default: br_cond = 1'b0;
        endcase
    end

    assign ex.PCSrcE    = ex.ValidE & (ex.JumpE | (ex.BranchE & br_cond));
    assign ex.PCTargetE = ex.JalrE ? ((src_a + ex.ImmExtE) & ~XLEN'(1)) : (ex.PCE + ex.ImmExtE);

    md_unit_iter #(.XLEN(XLEN)) u_md (
        .clk     (clk),
        .rst     (rst),
        .start   (ex.ValidE & ex.MdEnE),
        .abort   (ex.FlushE),
        .op      (ex.MdOpE),
        .a       (src_a),
        .b       (fwd_b),
        .busy    (md_busy),
        .done    (md_done),
        .result  (md_result),
        .state_o (md_state)
    );

    assign stall       = ex.ValidE & ex.MdEnE & ~md_done & ~ex.FlushE;
    assign ex.StallE   = stall;
    assign ex.MdStateE = md_state;

    // MEM sees bubbles for the whole time the M-unit is iterating.
    always_comb begin
        bubble        = stall | ex.FlushE | md_busy;
        regwrite_m_d  = 1'b0;
        memwrite_m_d  = 1'b0;
        resultsrc_m_d = '0;
        aluresult_m_d = '0;
        writedata_m_d = '0;
        pcplus4_m_d   = '0;
        rd_m_d        = '0;
        if (!bubble) begin
            regwrite_m_d  = ex.RegWriteE;
            memwrite_m_d  = ex.MemWriteE;
            resultsrc_m_d = ex.ResultSrcE;
            aluresult_m_d = md_done ? md_result : alu_result;
            writedata_m_d = fwd_b;
            pcplus4_m_d   = ex.PCPlus4E;
            rd_m_d        = ex.RdE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwrite_m_q  <= 1'b0;
            memwrite_m_q  <= 1'b0;
            resultsrc_m_q <= '0;
            aluresult_m_q <= '0;
            writedata_m_q <= '0;
            pcplus4_m_q   <= '0;
            rd_m_q        <= '0;
        end else begin
            regwrite_m_q  <= regwrite_m_d;
            memwrite_m_q  <= memwrite_m_d;
            resultsrc_m_q <= resultsrc_m_d;
            aluresult_m_q <= aluresult_m_d;
            writedata_m_q <= writedata_m_d;
            pcplus4_m_q   <= pcplus4_m_d;
            rd_m_q        <= rd_m_d;
        end
    end

    assign ex.RegWriteM  = regwrite_m_q;
    assign ex.MemWriteM  = memwrite_m_q;
    assign ex.ResultSrcM = resultsrc_m_q;
    assign ex.ALUResultM = aluresult_m_q;
    assign ex.WriteDataM = writedata_m_q;
    assign ex.PCPlus4M   = pcplus4_m_q;
    assign ex.RdM        = rd_m_q;

endmodule

// File: tb/tb_execute_stage_md.sv
// Directed and randomized checks of execute_stage_md against an arithmetic reference model.
module tb_execute_stage_md;
    import execute_pkg::*;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    logic clk = 1'b0;
    logic rst;

    execute_stage_md_if #(.XLEN(XLEN), .REG_AW(REG_AW)) ex ();
    execute_stage_md #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (.clk(clk), .rst(rst), .ex(ex));

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    logic [XLEN-1:0] exp_alu_m = '0;
    logic [XLEN-1:0] exp_q[$];

    logic [3:0]  s_op;
    logic [31:0] s_rd1, s_rd2, s_imm, s_pc, s_resw;
    logic [1:0]  s_fa, s_fb;
    logic        s_alusrc, s_branch, s_jump, s_jalr, s_flush;
    logic [2:0]  s_bop;

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_fwd(logic [31:0] rd, logic [1:0] sel, logic [31:0] w, logic [31:0] m);
        if (sel == 2'b01) return w;
        if (sel == 2'b10) return m;
        return rd;
    endfunction

    function automatic logic [31:0] m_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        int sa = a;
        int sb = b;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd6:  return (a < b) ? 32'd1 : 32'd0;
            4'd7:  return a << b[4:0];
            4'd8:  return a >> b[4:0];
            4'd9:  return 32'(sa >>> b[4:0]);
            4'd10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_branch(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
        int sa = a;
        int sb = b;
        case (f3)
            3'b000: return a == b;
            3'b001: return a != b;
            3'b100: return sa < sb;
            3'b101: return sa >= sb;
            3'b110: return a < b;
            3'b111: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_md(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        int sa = a;
        int sb = b;
        logic [63:0] p;
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
            3'd2: begin p = longint'(sa) * longint'({32'b0, b}); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic clear_inputs();
        ex.ValidE = 0; ex.FlushE = 0; ex.RegWriteE = 0; ex.MemWriteE = 0; ex.BranchE = 0;
        ex.JumpE = 0; ex.JalrE = 0; ex.ALUSrcE = 0; ex.MdEnE = 0; ex.ResultSrcE = 0;
        ex.ALUControlE = 0; ex.BranchOpE = 0; ex.MdOpE = 0; ex.RD1E = 0; ex.RD2E = 0;
        ex.PCE = 0; ex.ImmExtE = 0; ex.PCPlus4E = 0; ex.ResultW = 0; ex.RdE = 0;
        ex.ForwardAE = 0; ex.ForwardBE = 0;
    endtask

    task automatic set_stim(input logic [3:0] op, input logic [31:0] rd1, input logic [31:0] rd2,
                            input logic [31:0] imm, input logic alusrc, input logic [1:0] fa);
        s_op = op; s_rd1 = rd1; s_rd2 = rd2; s_imm = imm; s_alusrc = alusrc; s_fa = fa;
        s_fb = 2'b00; s_pc = 32'h0000_1000; s_resw = $urandom; s_branch = 0; s_jump = 0;
        s_jalr = 0; s_flush = 0; s_bop = 3'b000;
    endtask

    // Called at a negedge; leaves the bench at the following negedge.
    task automatic apply_alu(input string tag);
        logic [31:0] a, fb_v, b, exp_res, exp_tgt, pc4;
        logic        exp_pcsrc, rw, mw;
        logic [1:0]  rs;
        logic [4:0]  rd;
        rw = 1'($urandom_range(0, 1)); mw = 1'($urandom_range(0, 1));
        rs = 2'($urandom_range(0, 3)); rd = 5'($urandom_range(1, 31)); pc4 = s_pc + 32'd4;
        ex.ValidE = 1; ex.FlushE = s_flush; ex.MdEnE = 0; ex.RegWriteE = rw; ex.MemWriteE = mw;
        ex.ResultSrcE = rs; ex.RdE = rd; ex.ALUControlE = s_op; ex.RD1E = s_rd1; ex.RD2E = s_rd2;
        ex.ImmExtE = s_imm; ex.PCE = s_pc; ex.PCPlus4E = pc4; ex.ResultW = s_resw;
        ex.ForwardAE = s_fa; ex.ForwardBE = s_fb; ex.ALUSrcE = s_alusrc; ex.BranchE = s_branch;
        ex.JumpE = s_jump; ex.JalrE = s_jalr; ex.BranchOpE = s_bop;
        a         = m_fwd(s_rd1, s_fa, s_resw, exp_alu_m);
        fb_v      = m_fwd(s_rd2, s_fb, s_resw, exp_alu_m);
        b         = s_alusrc ? s_imm : fb_v;
        exp_res   = m_alu(s_op, a, b);
        exp_pcsrc = s_jump | (s_branch & m_branch(s_bop, a, fb_v));
        exp_tgt   = s_jalr ? ((a + s_imm) & 32'hFFFF_FFFE) : (s_pc + s_imm);
        #1;
        check({tag, "_pcsrc"}, 32'(ex.PCSrcE), 32'(exp_pcsrc));
        check({tag, "_target"}, ex.PCTargetE, exp_tgt);
        check({tag, "_stall"}, 32'(ex.StallE), 32'd0);
        @(negedge clk);
        if (s_flush) begin
            rw = 0; mw = 0; rs = 0; rd = 0; exp_res = 0; fb_v = 0; pc4 = 0;
        end
        check({tag, "_alu_m"}, ex.ALUResultM, exp_res);
        check({tag, "_wdata_m"}, ex.WriteDataM, fb_v);
        check({tag, "_regwrite_m"}, 32'(ex.RegWriteM), 32'(rw));
        check({tag, "_memwrite_m"}, 32'(ex.MemWriteM), 32'(mw));
        check({tag, "_ressrc_m"}, 32'(ex.ResultSrcM), 32'(rs));
        check({tag, "_rd_m"}, 32'(ex.RdM), 32'(rd));
        check({tag, "_pc4_m"}, ex.PCPlus4M, pc4);
        exp_alu_m = exp_res;
    endtask

    task automatic issue_md(input logic [2:0] op, input logic [31:0] rd1, input logic [31:0] rd2,
                            input logic [31:0] resw, input logic [1:0] fa, input logic [1:0] fb,
                            input logic [4:0] rd);
        clear_inputs();
        ex.ValidE = 1; ex.MdEnE = 1; ex.MdOpE = op; ex.RD1E = rd1; ex.RD2E = rd2;
        ex.ResultW = resw; ex.ForwardAE = fa; ex.ForwardBE = fb; ex.RegWriteE = 1; ex.RdE = rd;
        ex.PCPlus4E = $urandom;
    endtask

    // Issues one M-op at a negedge, counts stall cycles, checks the result in MEM.
    task automatic run_md(input logic [2:0] op, input logic [31:0] rd1, input logic [31:0] rd2,
                          input logic [31:0] resw, input logic [1:0] fa, input logic [1:0] fb,
                          input string tag);
        int stall_cnt;
        logic bubbles_ok;
        logic [4:0] rd;
        logic [31:0] exp_v;
        rd = 5'($urandom_range(1, 31));
        issue_md(op, rd1, rd2, resw, fa, fb, rd);
        exp_q.push_back(m_md(op, m_fwd(rd1, fa, resw, exp_alu_m), m_fwd(rd2, fb, resw, exp_alu_m)));
        stall_cnt  = 0;
        bubbles_ok = 1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (!ex.StallE) break;
            stall_cnt++;
            if (c > 0 && (ex.RegWriteM !== 1'b0 || ex.ALUResultM !== 32'd0)) bubbles_ok = 0;
            @(negedge clk);
            ex.RD1E = $urandom; ex.RD2E = $urandom; ex.ResultW = $urandom;
        end
        check({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(XLEN + 1));
        check({tag, "_bubbles"}, 32'(bubbles_ok), 32'd1);
        @(negedge clk);
        exp_v = exp_q.pop_front();
        check({tag, "_result"}, ex.ALUResultM, exp_v);
        check({tag, "_regwrite_m"}, 32'(ex.RegWriteM), 32'd1);
        check({tag, "_rd_m"}, 32'(ex.RdM), 32'(rd));
        exp_alu_m = exp_v;
        ex.ValidE = 0; ex.MdEnE = 0;
    endtask

    // ---------------- sequence ----------------
    initial begin
        clear_inputs();
        rst = 1;
        #1;
        check("reset_state", 32'(ex.MdStateE), 32'(S_IDLE));
        check("reset_alu_m", ex.ALUResultM, 32'd0);
        check("reset_regwrite_m", 32'(ex.RegWriteM), 32'd0);
        check("reset_pc4_m", ex.PCPlus4M, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;

        // forwarding from ALUResultM
        set_stim(ALU_ADD, 32'd4, 32'd0, 32'd3, 1'b1, 2'b00);
        apply_alu("add_seed");
        set_stim(ALU_ADD, 32'd5, 32'd0, 32'd3, 1'b1, 2'b10);
        apply_alu("add_fwd_m");

        // signed vs unsigned compare and JALR alignment
        set_stim(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0, 2'b00);
        s_branch = 1; s_bop = BR_LTU;
        apply_alu("bltu");
        set_stim(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0, 2'b00);
        s_branch = 1; s_bop = BR_LT;
        apply_alu("blt");
        set_stim(ALU_ADD, 32'h0000_1003, 32'd0, 32'd0, 1'b1, 2'b00);
        s_jump = 1; s_jalr = 1;
        apply_alu("jalr");

        // M-extension results and corner cases
        run_md(MD_MULH, 32'hFFFF_FFFE, 32'd3, 32'd0, 2'b00, 2'b00, "mulh");
        run_md(MD_MUL, 32'hFFFF_FFFE, 32'd3, 32'd0, 2'b00, 2'b00, "mul");
        run_md(MD_DIV, 32'd7, 32'd0, 32'd0, 2'b00, 2'b00, "div_by_zero");
        run_md(MD_REMU, 32'd7, 32'd0, 32'd0, 2'b00, 2'b00, "remu_by_zero");
        run_md(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2'b00, 2'b00, "div_ovf");
        run_md(MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2'b00, 2'b00, "rem_ovf");
        run_md(MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 2'b00, 2'b00, "div_neg");
        run_md(MD_REM, 32'hFFFF_FFF9, 32'd2, 32'd0, 2'b00, 2'b00, "rem_neg");

        // flush part-way through a divide
        issue_md(MD_DIV, 32'd100, 32'd7, 32'd0, 2'b00, 2'b00, 5'd9);
        repeat (10) @(negedge clk);
        ex.FlushE = 1;
        #1;
        check("flush_stall", 32'(ex.StallE), 32'd0);
        @(negedge clk);
        check("flush_state", 32'(ex.MdStateE), 32'(S_IDLE));
        check("flush_regwrite_m", 32'(ex.RegWriteM), 32'd0);
        check("flush_alu_m", ex.ALUResultM, 32'd0);
        exp_alu_m = 0;
        set_stim(ALU_ADD, 32'd20, 32'd22, 32'd0, 1'b0, 2'b00);
        apply_alu("add_after_flush");

        // asynchronous reset while iterating
        issue_md(MD_MUL, 32'd3, 32'd5, 32'd0, 2'b00, 2'b00, 5'd4);
        repeat (5) @(negedge clk);
        #2 rst = 1;
        #1;
        check("rst_busy_state", 32'(ex.MdStateE), 32'(S_IDLE));
        check("rst_busy_regwrite_m", 32'(ex.RegWriteM), 32'd0);
        check("rst_busy_alu_m", ex.ALUResultM, 32'd0);
        check("rst_busy_rd_m", 32'(ex.RdM), 32'd0);
        @(negedge clk);
        rst = 0;
        exp_alu_m = 0;
        run_md(MD_MUL, 32'd6, 32'd7, 32'd0, 2'b00, 2'b00, "mul_after_rst");

        // randomized single-cycle instructions
        for (int i = 0; i < 30; i++) begin
            set_stim(4'($urandom_range(0, 15)), $urandom, $urandom, $urandom,
                     1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            s_fb = 2'($urandom_range(0, 3));
            s_branch = 1'($urandom_range(0, 1));
            s_jump = 1'($urandom_range(0, 3) == 0);
            s_jalr = 1'($urandom_range(0, 1));
            s_bop = 3'($urandom_range(0, 7));
            s_flush = 1'($urandom_range(0, 7) == 0);
            if (i % 3 == 0) s_rd2 = s_rd1;
            apply_alu("rnd_alu");
        end

        // randomized back-to-back M-ops
        for (int i = 0; i < 12; i++) begin
            logic [31:0] r2;
            r2 = $urandom;
            if (i % 4 == 0) r2 = 32'd0;
            if (i % 5 == 1) r2 = $urandom_range(1, 20);
            run_md(3'($urandom_range(0, 7)), $urandom, r2, $urandom,
                   2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), "rnd_md");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/execute_stage_md.md
# execute_stage_md

Parametrised execute stage for the 5-stage pipelined RISC-V core: forwarding muxes, ALU, full RV32I branch/jump resolution and an iterative RV32M multiply/divide unit, feeding the EX/MEM pipeline register. It sits between the ID/EX register and the memory stage. It asserts `StallE` to freeze IF/ID/EX while a multi-cycle M-extension op runs, and inserts bubbles downstream during the stall.

## Interface
- `XLEN`, 32: datapath width. Must be ≥ 8 and a power of two.
- `REG_AW`, 5: register-index width.

- `clk`: in, 1, rising-edge clock.
- `rst`: in, 1, asynchronous, active-high reset.
- `ValidE`, `FlushE`: in, 1 each. Instruction valid in EX; squash EX (bubble into MEM, abort MD op).
- `RegWriteE`, `MemWriteE`, `BranchE`, `JumpE`, `JalrE`, `ALUSrcE`, `MdEnE`: in, 1 each, decoded controls.
- `ResultSrcE`: in, 2, result select passed to MEM/WB.
- `ALUControlE`: in, 4, ALU op.
- `BranchOpE`, `MdOpE`: in, 3 each, funct3 of branch / M-op.
- `RD1E`, `RD2E`, `PCE`, `ImmExtE`, `PCPlus4E`, `ResultW`: in, XLEN each.
- `RdE`: in, REG_AW.
- `ForwardAE`, `ForwardBE`: in, 2 each. 00 = RDxE, 01 = ResultW, 10 = ALUResultM, 11 = RDxE.
- `PCSrcE`: out, 1, redirect fetch.
- `PCTargetE`: out, XLEN.
- `StallE`: out, 1, hold IF/ID/EX.
- `RegWriteM`, `MemWriteM`: out, 1 each.
- `ResultSrcM`: out, 2.
- `ALUResultM`, `WriteDataM`, `PCPlus4M`: out, XLEN each.
- `RdM`: out, REG_AW.

## Operation
- **Operands**
  - SrcA = fwd(RD1E, ForwardAE).
  - FwdB = fwd(RD2E, ForwardBE).
  - SrcB = ALUSrcE ? ImmExtE : FwdB.
  - WriteData = FwdB.
- **ALU ops**
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 PASS-B (LUI).
  - Codes 11–15 produce 0.
  - Shifts use SrcB[log2(XLEN)-1:0].
  - All arithmetic is modulo 2^XLEN.
- **Branch compare** (on SrcA vs FwdB)
  - 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU.
  - 010 and 011 are never taken.
- **Redirect**
  - PCSrcE = ValidE & (JumpE | (BranchE & cond)).
  - PCTargetE = JalrE ? (SrcA + ImmExtE) & ~1 : PCE + ImmExtE.
- **MD FSM states**: IDLE, BUSY, DONE.
  - IDLE → BUSY when ValidE & MdEnE & ~FlushE. Latch SrcA/FwdB magnitudes, signs and op; clear counter.
  - BUSY: one radix-2 shift-add (MUL*) or restoring shift-subtract (DIV*/REM*) step per cycle. After XLEN steps, go to DONE.
  - DONE: sign-correct the result, present it as the EX result, return to IDLE.
- **MdOpE**: 000 MUL (low), 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- **MD corner cases** (must match the ISA)
  - Divide by zero: quotient = all-ones, remainder = dividend.
  - Signed overflow (−2^(XLEN−1) / −1): quotient = dividend, remainder = 0.
- **StallE** = ValidE & MdEnE & (state != DONE) & ~FlushE.
- **EX/MEM register**
  - Loads a bubble (RegWriteM = MemWriteM = 0, RdM = 0, others 0) when StallE or FlushE.
  - Otherwise loads the EX values. ALUResultM = MD result in DONE, else ALU result.
- **Flush** in BUSY or DONE aborts to IDLE; no result is written.

## Timing
- Reset (async): FSM = IDLE, counter = 0, all `*M` outputs = 0. StallE and PCSrcE follow from their inputs.
- Non-MD instruction: 1 cycle in EX; registered into MEM at the next edge.
- MD instruction issued at cycle T:
  - StallE high in cycles T … T+XLEN.
  - DONE in cycle T+XLEN+1, StallE low.
  - Result in ALUResultM after the edge ending T+XLEN+1.
  - Latency in EX is XLEN+2 cycles; back-to-back MD ops re-enter IDLE→BUSY with no gap cycle beyond that.
- PCSrcE and PCTargetE are combinational in the same cycle. PCSrcE is never asserted by an MD op.
- Forwarded operands are sampled only at issue. ResultW and ALUResultM changes during BUSY are ignored.
- FlushE and issue in the same cycle: flush wins, no issue.
- Reset during BUSY: immediate return to IDLE.

## Structure
- Shared package `execute_pkg`: ALU op codes, branch funct3 codes, MD op codes, forward-select codes, FSM state enum.
- Sub-module `md_unit_iter` holds the FSM, counter, iterative multiply/divide datapath and sign/corner fixup.
  - Handshake: start, op, a, b in; busy, done, result out; abort in.
- Forwarding, ALU, branch compare, target adder and EX/MEM register stay in `execute_stage_md`.

## Test plan
- **ADD with forwarding**: RD1E = 5, ForwardAE = 10, ALUResultM = 7, imm = 3, ALUSrcE = 1 → ALUResultM = 10 next cycle, StallE = 0.
- **BLTU vs BLT**: SrcA = 0xFFFFFFFF, SrcB = 1.
  - BranchOpE = 110 → PCSrcE = 0.
  - BranchOpE = 100 → PCSrcE = 1, PCTargetE = PCE + ImmExtE.
  - JALR with SrcA = 0x1003, imm = 0 → PCTargetE = 0x1002.
- **MULH**: −2 × 3 → StallE high exactly 33 cycles, RegWriteM = 0 during them, then ALUResultM = 0xFFFFFFFF. MUL with the same operands → 0xFFFFFFFA.
- **DIV corners**:
  - 7/0 → 0xFFFFFFFF.
  - REMU 7 % 0 → 7.
  - 0x80000000 / −1 → 0x80000000.
  - REM of the same operands → 0.
  - DIV −7/2 → −3, REM → −1.
- **FlushE mid-op**: FlushE at cycle T+10 of a DIV → FSM IDLE, StallE low, bubble in MEM, no result written. A following ADD completes in 1 cycle.
- **Reset mid-op**: rst pulse during BUSY → all `*M` = 0 immediately and the FSM is IDLE. A new MUL 6 × 7 → 42 after XLEN+2 cycles.
